// File: rtl/dmg_pkg.sv
// Shared DMG LCD / frame-buffer definitions used by capture and VGA scan-out.
package dmg_pkg;

    localparam int H_PIXELS   = 160;
    localparam int V_PIXELS   = 144;
    localparam int ADDR_WIDTH = 15;
    localparam int DATA_WIDTH = 2;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } capture_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for one async level, plus a history flop that
// turns the synced level into single-cycle rise/fall pulses.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;

    // Shift the async input down the chain; history holds the previous synced level.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_i};
        hist_d = sync_q[STAGES-1];
    end

    // Synchronizer and history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/dmg_lcd_capture.sv
// Samples the raw DMG LCD bus in the VGA clock domain and produces linear
// frame-buffer write strobes, frame boundary pulses and a sticky line error.
module dmg_lcd_capture #(
    parameter int H_PIXELS    = dmg_pkg::H_PIXELS,
    parameter int V_PIXELS    = dmg_pkg::V_PIXELS,
    parameter int ADDR_WIDTH  = dmg_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = dmg_pkg::DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK25MHz,
    input  logic                  reset_n,
    input  logic                  lcd_cp,
    input  logic                  lcd_hsync,
    input  logic                  lcd_vsync,
    input  logic [DATA_WIDTH-1:0] lcd_d,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic                  line_err
);

    import dmg_pkg::*;

    localparam int X_W = $clog2(H_PIXELS + 1);
    localparam int Y_W = $clog2(V_PIXELS);

    localparam logic [X_W-1:0]        X_FULL    = X_W'(H_PIXELS);
    localparam logic [X_W-1:0]        X_LAST    = X_W'(H_PIXELS - 1);
    localparam logic [Y_W-1:0]        Y_LAST    = Y_W'(V_PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(H_PIXELS);

    logic cp_level_unused, cp_rise_unused, cp_fall;
    logic hs_level_unused, hs_rise, hs_fall_unused;
    logic vs_level_unused, vs_rise, vs_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cp (
        .clk(CLK25MHz), .rst_n(reset_n), .async_i(lcd_cp),
        .level_o(cp_level_unused), .rise_o(cp_rise_unused), .fall_o(cp_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_hsync (
        .clk(CLK25MHz), .rst_n(reset_n), .async_i(lcd_hsync),
        .level_o(hs_level_unused), .rise_o(hs_rise), .fall_o(hs_fall_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vsync (
        .clk(CLK25MHz), .rst_n(reset_n), .async_i(lcd_vsync),
        .level_o(vs_level_unused), .rise_o(vs_rise), .fall_o(vs_fall_unused)
    );

    logic [DATA_WIDTH-1:0] dsync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] dsync_d [SYNC_STAGES];

    // Pixel data chain, same depth as the strobes so the sample lines up with the cp fall.
    always_comb begin
        dsync_d[0] = lcd_d;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            dsync_d[i] = dsync_q[i-1];
        end
    end

    // Pixel data synchronizer registers.
    always_ff @(posedge CLK25MHz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                dsync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                dsync_q[i] <= dsync_d[i];
            end
        end
    end

    capture_state_t        state_q, state_d;
    logic [X_W-1:0]        x_q, x_d, x_after;
    logic [Y_W-1:0]        y_q, y_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  pix_write;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  frame_start_q, frame_start_d;
    logic                  frame_done_q, frame_done_d;
    logic                  line_err_q, line_err_d;

    // State register plus all position and output registers.
    always_ff @(posedge CLK25MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= WAIT_FRAME;
            x_q           <= '0;
            y_q           <= '0;
            base_q        <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            line_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            base_q        <= base_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            line_err_q    <= line_err_d;
        end
    end

    // Next state: vsync always (re)starts a frame; hsync on the last line ends it.
    always_comb begin
        state_d = state_q;
        if (vs_rise) begin
            state_d = ACTIVE;
        end else if (state_q == ACTIVE && hs_rise && y_q >= Y_LAST) begin
            state_d = WAIT_FRAME;
        end
    end

    // Datapath/outputs: vsync beats everything; a cp fall lands before a same-cycle hsync.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        base_d        = base_q;
        x_after       = x_q;
        pix_write     = 1'b0;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        line_err_d    = line_err_q;
        if (vs_rise) begin
            x_d           = '0;
            y_d           = '0;
            base_d        = '0;
            frame_start_d = 1'b1;
            line_err_d    = 1'b0;
        end else if (state_q == ACTIVE) begin
            pix_write = cp_fall && (x_q < X_FULL) && (y_q <= Y_LAST);
            x_after   = x_q + {{(X_W-1){1'b0}}, pix_write};
            if (pix_write) begin
                wr_en_d      = 1'b1;
                wr_addr_d    = base_q + ADDR_WIDTH'(x_q);
                wr_data_d    = dsync_q[SYNC_STAGES-1];
                frame_done_d = (x_q == X_LAST) && (y_q == Y_LAST);
            end
            x_d = x_after;
            if (hs_rise) begin
                if (x_after != X_FULL) begin
                    line_err_d = 1'b1;
                end
                x_d = '0;
                if (y_q < Y_LAST) begin
                    y_d    = y_q + 1'b1;
                    base_d = base_q + LINE_STEP;
                end
            end
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign line_err    = line_err_q;

endmodule

// File: tb/tb_dmg_lcd_capture.sv
// Scoreboard bench for dmg_lcd_capture; uses a short 8-line frame so whole
// frames fit in a small cycle budget while keeping the 160-pixel line width.
module tb_dmg_lcd_capture;

    localparam int H  = 160;
    localparam int V  = 8;
    localparam int AW = 15;
    localparam int DW = 2;

    localparam int K_PIX   = 0;
    localparam int K_HS    = 1;
    localparam int K_VS    = 2;
    localparam int K_PIXVS = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          lcd_cp, lcd_hsync, lcd_vsync;
    logic [DW-1:0] lcd_d;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          frame_start, frame_done, line_err;

    int  vectors     = 0;
    int  miscompares = 0;
    int  fs_seen = 0, fs_exp = 0;
    int  fd_seen = 0, fd_exp = 0;
    wr_t exp_q[$];
    wr_t e;

    bit  mdl_active = 1'b0;
    int  mdl_x = 0, mdl_y = 0;
    bit  mdl_err = 1'b0;

    dmg_lcd_capture #(
        .H_PIXELS(H), .V_PIXELS(V), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(2)
    ) dut (
        .CLK25MHz(clk), .reset_n(reset_n),
        .lcd_cp(lcd_cp), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_d(lcd_d),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_start(frame_start), .frame_done(frame_done), .line_err(line_err)
    );

    always #20 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic modelPixel(input logic [DW-1:0] d);
        if (mdl_active && mdl_x < H) begin
            exp_q.push_back('{addr: AW'(mdl_y * H + mdl_x), data: d});
            if (mdl_x == H - 1 && mdl_y == V - 1) fd_exp++;
            mdl_x++;
        end
    endtask

    task automatic modelHsync();
        if (mdl_active) begin
            if (mdl_x != H) mdl_err = 1'b1;
            mdl_x = 0;
            if (mdl_y < V - 1) mdl_y++;
            else mdl_active = 1'b0;
        end
    endtask

    task automatic modelVsync();
        mdl_active = 1'b1;
        mdl_x = 0;
        mdl_y = 0;
        mdl_err = 1'b0;
        fs_exp++;
    endtask

    task automatic applyStimulus(input int kind, input logic [DW-1:0] d);
        case (kind)
            K_PIX: begin
                lcd_d = d; lcd_cp = 1'b1;
                repeat (2) @(negedge clk);
                lcd_cp = 1'b0; modelPixel(d);
                repeat (2) @(negedge clk);
            end
            K_HS: begin
                lcd_hsync = 1'b1; modelHsync();
                repeat (2) @(negedge clk);
                lcd_hsync = 1'b0;
                repeat (2) @(negedge clk);
            end
            K_VS: begin
                lcd_vsync = 1'b1; modelVsync();
                repeat (2) @(negedge clk);
                lcd_vsync = 1'b0;
                repeat (2) @(negedge clk);
            end
            default: begin
                lcd_d = d; lcd_cp = 1'b1;
                repeat (2) @(negedge clk);
                lcd_cp = 1'b0; lcd_vsync = 1'b1; modelVsync();
                repeat (2) @(negedge clk);
                lcd_vsync = 1'b0;
                repeat (2) @(negedge clk);
            end
        endcase
    endtask

    task automatic sendLine(input int n, input int y);
        for (int x = 0; x < n; x++) applyStimulus(K_PIX, DW'((x + y) % 4));
        applyStimulus(K_HS, '0);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic checkIdleOutputs(input string phase);
        checkOutput({phase, "_wr_en"},       32'(wr_en),       0);
        checkOutput({phase, "_wr_addr"},     32'(wr_addr),     0);
        checkOutput({phase, "_wr_data"},     32'(wr_data),     0);
        checkOutput({phase, "_frame_start"}, 32'(frame_start), 0);
        checkOutput({phase, "_frame_done"},  32'(frame_done),  0);
        checkOutput({phase, "_line_err"},    32'(line_err),    0);
    endtask

    // Output monitor: every write is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_wr_en", 32'(wr_en), 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("wr_addr", 32'(wr_addr), 32'(e.addr));
                checkOutput("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
        if (frame_start) fs_seen++;
        if (frame_done) begin
            fd_seen++;
            checkOutput("frame_done_addr", 32'(wr_addr), H * V - 1);
            checkOutput("frame_done_with_wr", 32'(wr_en), 1);
        end
    end

    initial begin
        #4_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got %0d vectors, expected completion", vectors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n = 1'b0; lcd_cp = 1'b0; lcd_hsync = 1'b0; lcd_vsync = 1'b0; lcd_d = '0;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Pre-frame noise: nothing may be written.
        for (int i = 0; i < 5; i++) applyStimulus(K_PIX, 2'd1);
        applyStimulus(K_HS, '0);
        settle();
        checkOutput("noise_no_writes", 32'(exp_q.size()), 0);

        // Frame 1 with latency check on its first pixel.
        applyStimulus(K_VS, '0);
        lcd_d = 2'b11; lcd_cp = 1'b1;
        repeat (2) @(negedge clk);
        lcd_cp = 1'b0; modelPixel(2'b11);
        @(posedge clk); @(negedge clk);
        checkOutput("lat_n", 32'(wr_en), 0);
        @(posedge clk); @(negedge clk);
        checkOutput("lat_n1", 32'(wr_en), 0);
        @(posedge clk); @(negedge clk);
        checkOutput("lat_n2_wr_en", 32'(wr_en), 1);
        checkOutput("lat_n2_addr", 32'(wr_addr), 0);
        checkOutput("lat_n2_data", 32'(wr_data), 3);
        @(negedge clk);
        checkOutput("lat_one_cycle", 32'(wr_en), 0);
        for (int x = 1; x < H; x++) applyStimulus(K_PIX, DW'(x % 4));
        applyStimulus(K_HS, '0);
        for (int y = 1; y < V; y++) sendLine(H, y);
        settle();
        checkOutput("frame1_line_err", 32'(line_err), 0);
        checkOutput("frame1_done_count", 32'(fd_seen), 1);

        // Frame 2: short line 5, long line 6.
        applyStimulus(K_VS, '0);
        for (int y = 0; y < 5; y++) sendLine(H, y);
        sendLine(158, 5);
        settle();
        checkOutput("line_err_set", 32'(line_err), 32'(mdl_err));
        checkOutput("line_err_set_abs", 32'(line_err), 1);
        sendLine(163, 6);
        sendLine(H, 7);
        settle();
        checkOutput("line_err_sticky", 32'(line_err), 1);
        applyStimulus(K_VS, '0);
        settle();
        checkOutput("line_err_cleared", 32'(line_err), 0);

        // Frame 3: reset in the middle of line 4.
        for (int y = 0; y < 4; y++) sendLine(H, y);
        for (int x = 0; x < 50; x++) applyStimulus(K_PIX, DW'(x % 4));
        settle();
        checkOutput("pre_reset_drained", 32'(exp_q.size()), 0);
        reset_n = 1'b0;
        mdl_active = 1'b0; mdl_x = 0; mdl_y = 0; mdl_err = 1'b0;
        @(negedge clk);
        checkIdleOutputs("midreset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) applyStimulus(K_PIX, 2'd2);
        applyStimulus(K_HS, '0);
        settle();
        checkIdleOutputs("post_reset");

        // Frame 4: restart at addr 0, then vsync colliding with a cp fall.
        applyStimulus(K_VS, '0);
        for (int x = 0; x < 10; x++) applyStimulus(K_PIX, DW'((x * 3) % 4));
        applyStimulus(K_PIXVS, 2'd3);
        for (int x = 0; x < 3; x++) applyStimulus(K_PIX, DW'(x + 1));
        settle();

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);
        checkOutput("frame_start_count", 32'(fs_seen), 32'(fs_exp));
        checkOutput("frame_done_count", 32'(fd_seen), 32'(fd_exp));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
